// File: rtl/ex_arb_pkg.sv
// rtl/ex_arb_pkg.sv - shared types and constants for the ex_ce_arbiter slice
//
// Contents:
//   arb_state_e  - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   DEF_DATA_W   - default datapath word width
//   TO_CNT_W     - width of the WAIT watchdog counter (EX_ARB_TIMEOUT_EN builds)
package ex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int TO_CNT_W   = 16;

endpackage

// File: rtl/ex_rr_pick.sv
// rtl/ex_rr_pick.sv - combinational round-robin selector
//
// Ports:
//   req         in   N_REQ          request lines
//   ptr         in   $clog2(N_REQ)  index of the last winner; search starts at ptr+1
//   grant_valid out  1              at least one request is set
//   grant_id    out  $clog2(N_REQ)  first set request at or after ptr+1, wrapping
module ex_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] idx;

    // Walk from the farthest candidate (ptr itself) towards the nearest
    // (ptr+1); the last hit written is therefore the highest-priority one.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = ID_W'((int'(ptr) + off) % N_REQ);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/ex_ce_arbiter.sv
// rtl/ex_ce_arbiter.sv - round-robin arbiter/sequencer for a shared clock-enabled datapath
//
// One transaction in flight: IDLE (arbitrate) -> ISSUE (ack + dp_ce) -> WAIT
// (first dp_data_valid) -> RESP (resp_valid) -> IDLE.
// Optional feature macro: EX_ARB_TIMEOUT_EN - WAIT watchdog of TIMEOUT cycles,
// aborting with resp_err=1 and resp_data=0. Undefined: WAIT is unbounded and
// resp_err stays 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req, req_data       request lines and packed words (requester i at [i*DATA_W +: DATA_W])
//   req_ack             one-hot acceptance pulse (ISSUE cycle)
//   dp_ce, dp_data_in   datapath enable pulse and its word (word holds between issues)
//   dp_data_valid/out   datapath result strobe and signed result
//   resp_valid          one-cycle response strobe
//   resp_id/data/err    response tag, result, timeout flag (held until next response)
//   busy                state is not IDLE
module ex_ce_arbiter
    import ex_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ack,
    output logic                     dp_ce,
    output logic [DATA_W-1:0]        dp_data_in,
    input  logic                     dp_data_valid,
    input  logic [DATA_W-1:0]        dp_data_out,
    output logic                     resp_valid,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    output logic                     busy
);

    localparam int ID_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic              timeout_hit;

    ex_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req         (req),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

`ifdef EX_ARB_TIMEOUT_EN
    // Counts completed WAIT cycles; cleared while in ISSUE so it reads 0 on
    // the first WAIT cycle. Abort fires on the TIMEOUT-th WAIT cycle.
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    logic [TO_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && (cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            word_q      <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            word_q      <= word_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Next-state and captured-data logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        word_d      = word_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ISSUE;
                    id_d    = grant_id;
                    ptr_d   = grant_id;
                    word_d  = req_data[int'(grant_id)*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Data takes precedence over a coincident timeout.
                if (dp_data_valid) begin
                    state_d     = RESP;
                    resp_id_d   = id_q;
                    resp_data_d = dp_data_out;
                    resp_err_d  = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    resp_id_d   = id_q;
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        req_ack    = '0;
        dp_ce      = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        if (state_q == ISSUE) begin
            req_ack[id_q] = 1'b1;
            dp_ce         = 1'b1;
        end
        if (state_q == RESP) begin
            resp_valid = 1'b1;
        end
        if (state_q != IDLE) begin
            busy = 1'b1;
        end
    end

    assign dp_data_in = word_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ex_ce_arbiter.sv
// tb/tb_ex_ce_arbiter.sv - self-checking bench for ex_ce_arbiter
module tb_ex_ce_arbiter;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int TB_TO = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_ack;
    logic             dp_ce;
    logic [W-1:0]     dp_data_in;
    logic             dp_data_valid = 1'b0;
    logic [W-1:0]     dp_data_out = '0;
    logic             resp_valid;
    logic [1:0]       resp_id;
    logic [W-1:0]     resp_data;
    logic             resp_err;
    logic             busy;

    ex_ce_arbiter #(
        .N_REQ   (N),
        .DATA_W  (W),
        .TIMEOUT (TB_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .req_ack       (req_ack),
        .dp_ce         (dp_ce),
        .dp_data_in    (dp_data_in),
        .dp_data_valid (dp_data_valid),
        .dp_data_out   (dp_data_out),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    longint edge_n = 0;

    // stimulus state and policy
    logic [N-1:0] s_req = '0;
    logic [W-1:0] s_data [N];
    int  p_req = 0, p_drop = 0, p_spur = 0;
    bit  hold_all = 0, spur_all = 0;
    int  l_min = 1, l_max = 6, force_L = 0;
    bit  use_force_res = 0;
    logic [W-1:0] force_res = '0;

    // reference model: timeline of the current transaction
    bit     m_act = 0, m_err = 0;
    longint m_g = 0, m_r = 0, m_next_ok = 0;
    int     m_id = 0, m_L = 1, m_ptr = N - 1;
    logic [W-1:0] m_word = '0, m_res = '0;
    logic [W-1:0] e_din = '0, e_rdata = '0;
    int     e_rid = 0;
    bit     e_rerr = 0, e_issue = 0, e_busy = 0, e_rv = 0;

    // observations of the DUT for the literal checks
    int     obs_ack[$];
    int     obs_resp_cnt = 0, obs_rid = 0, obs_first_rid = -1;
    longint obs_ack_cyc = 0, obs_resp_cyc = 0;
    logic [W-1:0] obs_rdata = '0, obs_din = '0;
    bit     obs_rerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h required 0x%0h", nm, edge_n, act, exp);
        end
    endtask

    task automatic apply();
        req = s_req;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = s_data[i];
    endtask

    // Expected outputs for the cycle that begins at edge edge_n.
    task automatic model_edge();
        int w;
        edge_n++;
        if (m_act && edge_n > m_r) m_act = 0;
        if (!m_act && edge_n >= m_next_ok && s_req != '0) begin
            w = -1;
            for (int off = 1; off <= N; off++)
                if (w < 0 && s_req[(m_ptr + off) % N]) w = (m_ptr + off) % N;
            m_act  = 1;
            m_g    = edge_n;
            m_id   = w;
            m_ptr  = w;
            m_word = s_data[w];
            m_L    = (force_L > 0) ? force_L : int'($urandom_range(l_max, l_min));
            m_res  = use_force_res ? force_res : $urandom();
            m_err  = 0;
            m_r    = m_g + m_L + 1;
`ifdef EX_ARB_TIMEOUT_EN
            if (m_L > TB_TO) begin
                m_err = 1;
                m_r   = m_g + TB_TO + 1;
            end
`endif
            m_next_ok = m_r + 2;
            e_din     = m_word;
        end
        if (m_act && edge_n == m_r) begin
            e_rid   = m_id;
            e_rdata = m_err ? '0 : m_res;
            e_rerr  = m_err;
        end
        e_issue = m_act && (edge_n == m_g);
        e_busy  = m_act;
        e_rv    = m_act && (edge_n == m_r);
    endtask

    task automatic drive();
        bit in_wait;
        for (int i = 0; i < N; i++) begin
            if (!hold_all && m_act && edge_n == m_g + 1 && i == m_id) begin
                s_req[i] = 1'b0;
            end else if (!s_req[i]) begin
                if (hold_all || $urandom_range(99, 0) < p_req) begin
                    s_req[i]  = 1'b1;
                    s_data[i] = $urandom();
                end
            end else if (!(m_act && i == m_id && edge_n <= m_g) && !hold_all
                         && $urandom_range(99, 0) < p_drop) begin
                s_req[i] = 1'b0;
            end
        end
        apply();
        in_wait       = m_act && edge_n > m_g && edge_n < m_r;
        dp_data_valid = 1'b0;
        dp_data_out   = $urandom();
        if (m_act && !m_err && edge_n == m_g + m_L) begin
            dp_data_valid = 1'b1;
            dp_data_out   = m_res;
        end else if (!in_wait && (spur_all || $urandom_range(99, 0) < p_spur)) begin
            dp_data_valid = 1'b1;
        end
    endtask

    task automatic compare();
        logic [N-1:0] eack;
        eack = '0;
        if (e_issue) eack[m_id] = 1'b1;
        chk("req_ack",    req_ack,    eack);
        chk("dp_ce",      dp_ce,      e_issue);
        chk("dp_data_in", dp_data_in, e_din);
        chk("busy",       busy,       e_busy);
        chk("resp_valid", resp_valid, e_rv);
        chk("resp_id",    resp_id,    e_rid);
        chk("resp_data",  resp_data,  e_rdata);
        chk("resp_err",   resp_err,   e_rerr);
        if (req_ack != '0) begin
            for (int i = 0; i < N; i++) if (req_ack[i]) obs_ack.push_back(i);
            obs_ack_cyc = edge_n;
            obs_din     = dp_data_in;
        end
        if (resp_valid) begin
            if (obs_resp_cnt == 0) obs_first_rid = resp_id;
            obs_resp_cnt++;
            obs_resp_cyc = edge_n;
            obs_rdata    = resp_data;
            obs_rid      = resp_id;
            obs_rerr     = resp_err;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        drive();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_obs();
        obs_ack.delete();
        obs_resp_cnt  = 0;
        obs_first_rid = -1;
    endtask

    task automatic drain();
        p_req = 0; p_drop = 0; p_spur = 0; spur_all = 0; hold_all = 0;
        s_req = '0;
        apply();
        for (int c = 0; c < 100 && m_act; c++) cycle();
        cycle();
        cycle();
        chk("drain_busy", busy, 1'b0);
    endtask

    task automatic run_until_resp(input int budget);
        for (int c = 0; c < budget && obs_resp_cnt == 0; c++) cycle();
        cycle();
        cycle();
    endtask

    initial begin
        for (int i = 0; i < N; i++) s_data[i] = '0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_dp_ce", dp_ce, 0);
        chk("rst_dp_data_in", dp_data_in, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // fairness: all requests held high, grant order 0,1,2,3,0,1,2,3
        hold_all = 1;
        force_L  = 2;
        for (int i = 0; i < N; i++) s_data[i] = 32'hA000_0000 + i;
        s_req = '1;
        apply();
        clear_obs();
        for (int c = 0; c < 200 && obs_ack.size() < 8; c++) cycle();
        chk("fair_count", obs_ack.size(), 8);
        for (int i = 0; i < 8 && i < obs_ack.size(); i++) chk("fair_order", obs_ack[i], i % 4);
        for (int r = 0; r < N; r++) begin
            int k;
            k = 0;
            foreach (obs_ack[j]) if (obs_ack[j] == r) k++;
            chk("fair_per_req", k, 2);
        end
        drain();

        // single request: req[2], word 0x10, result -5 after L=3
        clear_obs();
        force_L = 3; use_force_res = 1; force_res = 32'hFFFF_FFFB;
        s_data[2] = 32'h0000_0010;
        s_req = 4'b0100;
        apply();
        run_until_resp(40);
        chk("single_acks", obs_ack.size(), 1);
        if (obs_ack.size() > 0) chk("single_ack_id", obs_ack[0], 2);
        chk("single_din", obs_din, 32'h0000_0010);
        chk("single_latency", obs_resp_cyc - obs_ack_cyc, 4);
        chk("single_resp_cnt", obs_resp_cnt, 1);
        chk("single_resp_id", obs_rid, 2);
        chk("single_resp_data", obs_rdata, 32'hFFFF_FFFB);
        chk("single_resp_err", obs_rerr, 0);
        drain();

        // spurious valid in IDLE, ISSUE and RESP: exactly one response
        clear_obs();
        force_res = 32'h1234_5678;
        spur_all  = 1;
        cycle(); cycle(); cycle();
        s_data[1] = 32'h0BAD_F00D;
        s_req = 4'b0010;
        apply();
        for (int c = 0; c < 40 && obs_resp_cnt == 0; c++) cycle();
        for (int c = 0; c < 4; c++) cycle();
        chk("spur_resp_cnt", obs_resp_cnt, 1);
        chk("spur_resp_id", obs_rid, 1);
        chk("spur_resp_data", obs_rdata, 32'h1234_5678);
        drain();

`ifdef EX_ARB_TIMEOUT_EN
        // datapath never answers: abort after TB_TO WAIT cycles
        clear_obs();
        force_L = 100;
        s_data[0] = 32'h5555_5555;
        s_req = 4'b0001;
        apply();
        run_until_resp(60);
        chk("to_latency", obs_resp_cyc - obs_ack_cyc, TB_TO + 1);
        chk("to_resp_err", obs_rerr, 1);
        chk("to_resp_data", obs_rdata, 0);
        drain();
`endif

        // randomized traffic
        force_L = 0; use_force_res = 0;
        l_min = 1;
`ifdef EX_ARB_TIMEOUT_EN
        l_max = TB_TO + 3;
`else
        l_max = 6;
`endif
        p_req = 30; p_drop = 5; p_spur = 20;
        clear_obs();
        for (int c = 0; c < 1500; c++) cycle();
        drain();

        // reset while in WAIT
        force_L = 8;
        s_data[3] = 32'h3333_3333;
        s_req = 4'b1000;
        apply();
        for (int c = 0; c < 20 && !(m_act && edge_n > m_g + 1); c++) cycle();
        s_req = '0;
        #2;
        rst = 1'b0;
        dp_data_valid = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dp_ce", dp_ce, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_req_ack", req_ack, 0);
        chk("mid_rst_resp_data", resp_data, 0);
        m_act = 0; m_ptr = N - 1; m_next_ok = 0;
        e_din = '0; e_rdata = '0; e_rid = 0; e_rerr = 0;
        e_issue = 0; e_busy = 0; e_rv = 0;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        for (int i = 0; i < N; i++) s_data[i] = 32'hC000_0000 + i;
        s_req = '1;
        apply();
        rst = 1'b1;
        clear_obs();
        force_L = 2;
        for (int c = 0; c < 12; c++) cycle();
        chk("post_rst_acks", obs_ack.size() > 0, 1);
        if (obs_ack.size() > 0) chk("post_rst_first_grant", obs_ack[0], 0);
        chk("post_rst_first_resp_id", obs_first_rid, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
